// File: rtl/multiplexor_rr_16x20.sv
// 16-to-1 round-robin valid/ready merger. Each accepted word leaves on a
// single registered output stream tagged with the index of its source
// channel, so a 16-way demultiplexor keyed on out_addr restores it.
//
// Handshake: a word moves on channel k when in_valid[k] && in_ready[k] at a
// rising clk edge, and on the output when out_valid && out_ready. in_ready
// is combinational and at most one bit is high (the granted channel). The
// output register accepts a new word whenever it is empty or being drained
// in the same cycle, so a steady stream runs at one word per cycle.
module multiplexor_rr_16x20 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] in0,
  input  logic [19:0] in1,
  input  logic [19:0] in2,
  input  logic [19:0] in3,
  input  logic [19:0] in4,
  input  logic [19:0] in5,
  input  logic [19:0] in6,
  input  logic [19:0] in7,
  input  logic [19:0] in8,
  input  logic [19:0] in9,
  input  logic [19:0] in10,
  input  logic [19:0] in11,
  input  logic [19:0] in12,
  input  logic [19:0] in13,
  input  logic [19:0] in14,
  input  logic [19:0] in15,
  input  logic [15:0] in_valid,
  output logic [15:0] in_ready,
  output logic [19:0] out,
  output logic [3:0]  out_addr,
  output logic        out_valid,
  input  logic        out_ready
);

  logic [19:0] in_data [16];

  logic [19:0] out_q,       out_d;
  logic [3:0]  out_addr_q,  out_addr_d;
  logic        out_valid_q, out_valid_d;
  logic [3:0]  ptr_q,       ptr_d;

  logic [3:0]  scan_idx;
  logic [3:0]  grant_idx;
  logic        grant_found;
  logic        load_en;
  logic        take;

  assign in_data[0]  = in0;
  assign in_data[1]  = in1;
  assign in_data[2]  = in2;
  assign in_data[3]  = in3;
  assign in_data[4]  = in4;
  assign in_data[5]  = in5;
  assign in_data[6]  = in6;
  assign in_data[7]  = in7;
  assign in_data[8]  = in8;
  assign in_data[9]  = in9;
  assign in_data[10] = in10;
  assign in_data[11] = in11;
  assign in_data[12] = in12;
  assign in_data[13] = in13;
  assign in_data[14] = in14;
  assign in_data[15] = in15;

  // Output register can take a word when empty or draining this cycle.
  assign load_en = !out_valid_q || out_ready;
  assign take    = grant_found && load_en;

  // Round-robin search: first valid channel starting at ptr, wrapping 15->0.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 4'd0;
    scan_idx    = 4'd0;
    for (int i = 0; i < 16; i++) begin
      scan_idx = ptr_q + 4'(i);
      if (!grant_found && in_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // One-hot ready for the granted channel; forced low while in reset.
  always_comb begin
    in_ready = 16'h0000;
    if (take && rst_n) begin
      in_ready = 16'h0001 << grant_idx;
    end
  end

  // Next state: load on grant, empty on idle drain, otherwise hold.
  always_comb begin
    out_d       = out_q;
    out_addr_d  = out_addr_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (take) begin
      out_d       = in_data[grant_idx];
      out_addr_d  = grant_idx;
      out_valid_d = 1'b1;
      ptr_d       = grant_idx + 4'd1;
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end
  end

  // State register; reset discards any held word immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= 20'h00000;
      out_addr_q  <= 4'h0;
      out_valid_q <= 1'b0;
      ptr_q       <= 4'h0;
    end else begin
      out_q       <= out_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out       = out_q;
  assign out_addr  = out_addr_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multiplexor_rr_16x20.sv
// Bench for multiplexor_rr_16x20: directed spec vectors followed by a long
// random run checked against a cycle-level arbiter model and a per-channel
// scoreboard that plays the role of the downstream demultiplexor.
module tb_multiplexor_rr_16x20;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [19:0] din [16];
  logic [15:0] in_valid = 16'h0000;
  logic [15:0] in_ready;
  logic [19:0] out;
  logic [3:0]  out_addr;
  logic        out_valid;
  logic        out_ready = 1'b0;

  multiplexor_rr_16x20 dut (
    .clk(clk), .rst_n(rst_n),
    .in0(din[0]),   .in1(din[1]),   .in2(din[2]),   .in3(din[3]),
    .in4(din[4]),   .in5(din[5]),   .in6(din[6]),   .in7(din[7]),
    .in8(din[8]),   .in9(din[9]),   .in10(din[10]), .in11(din[11]),
    .in12(din[12]), .in13(din[13]), .in14(din[14]), .in15(din[15]),
    .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .out_addr(out_addr), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // ---------------- reference model ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  int          m_ptr;
  logic        m_valid;
  logic [19:0] m_out;
  logic [3:0]  m_addr;
  int          cap_g;
  logic [19:0] exp_q [16][$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Channel chosen by the round-robin rule, or -1 when nothing is offered.
  function automatic int rr_pick(input logic [15:0] v, input int p);
    for (int i = 0; i < 16; i++) begin
      if (v[(p + i) % 16]) return (p + i) % 16;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 1'b0;
    m_out   = 20'h0;
    m_addr  = 4'h0;
    cap_g   = -1;
    for (int k = 0; k < 16; k++) exp_q[k].delete();
  endtask

  // Compare everything visible this cycle and capture the expected grant.
  task automatic check_all();
    logic        load;
    int          g;
    logic [15:0] exp_rdy;
    load    = !m_valid || out_ready;
    g       = rr_pick(in_valid, m_ptr);
    exp_rdy = (load && g >= 0) ? (16'h0001 << g) : 16'h0000;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out", 32'(out), 32'(m_out));
    chk("out_addr", 32'(out_addr), 32'(m_addr));
    if (out_valid && out_ready) begin
      if (exp_q[out_addr].size() == 0) begin
        chk("demux_unexpected_word", 32'(out), 32'hFFFF_FFFF);
      end else begin
        chk("demux_word", 32'(out), 32'(exp_q[out_addr].pop_front()));
      end
    end
    cap_g = load ? g : -2;
  endtask

  task automatic model_update();
    if (cap_g >= 0) begin
      m_out   = din[cap_g];
      m_addr  = 4'(cap_g);
      m_valid = 1'b1;
      m_ptr   = (cap_g + 1) % 16;
      exp_q[cap_g].push_back(din[cap_g]);
    end else if (cap_g == -1) begin
      m_valid = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_out_addr", 32'(out_addr), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    for (int k = 0; k < 16; k++) din[k] = 20'h0;
    model_reset();

    // Reset with every channel requesting.
    in_valid  = 16'hFFFF;
    out_ready = 1'b1;
    do_reset();

    // Single channel 5.
    in_valid = 16'h0020;
    din[5]   = 20'hABCDE;
    #1;
    chk("single_in_ready", 32'(in_ready), 32'h0020);
    step();
    in_valid = 16'h0000;
    chk("single_out", 32'(out), 32'hABCDE);
    chk("single_addr", 32'(out_addr), 32'h5);
    chk("single_valid", 32'(out_valid), 32'h1);
    step();

    // Full round-robin sweep from ptr 0, no bubbles.
    in_valid = 16'h0000;
    do_reset();
    for (int k = 0; k < 16; k++) din[k] = 20'(k);
    in_valid = 16'hFFFF;
    for (int i = 0; i < 17; i++) begin
      step();
      chk("rr_addr", 32'(out_addr), 32'(i % 16));
      chk("rr_valid", 32'(out_valid), 32'h1);
    end

    // Backpressure: hold 12345 from channel 3 while channel 4 waits.
    in_valid = 16'h0000;
    do_reset();
    din[3]   = 20'h12345;
    din[4]   = 20'h54321;
    in_valid = 16'h0008;
    step();
    out_ready = 1'b0;
    in_valid  = 16'h0010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_out", 32'(out), 32'h12345);
      chk("bp_addr", 32'(out_addr), 32'h3);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'h0010);
    step();
    in_valid = 16'h0000;
    chk("bp_next_addr", 32'(out_addr), 32'h4);
    step();

    // Wrap and skip: ptr to 14 via channel 13, then channels 0 and 1.
    din[13]  = 20'h0D0D0;
    in_valid = 16'h2000;
    step();
    din[0]   = 20'h00A00;
    din[1]   = 20'h00B01;
    in_valid = 16'h0003;
    step();
    chk("wrap_first", 32'(out_addr), 32'h0);
    step();
    chk("wrap_second", 32'(out_addr), 32'h1);
    din[2]   = 20'h00C02;
    in_valid = 16'h0005;
    step();
    chk("wrap_ptr2", 32'(out_addr), 32'h2);

    // Asynchronous reset while a word is held.
    out_ready = 1'b0;
    in_valid  = 16'h0100;
    din[8]    = 20'hFEDCB;
    step();
    chk("mid_held", 32'(out_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_out", 32'(out), 32'h0);
    chk("mid_rst_ready", 32'(in_ready), 32'h0);
    out_ready = 1'b1;
    in_valid  = 16'hFFFF;
    do_reset();
    step();
    chk("post_rst_first", 32'(out_addr), 32'h0);

    // Random traffic, scoreboard acts as the downstream demultiplexor.
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < 16; k++) din[k] = 20'($urandom);
      case ($urandom_range(0, 3))
        0:       in_valid = 16'h0000;
        1:       in_valid = 16'(1 << $urandom_range(0, 15));
        default: in_valid = 16'($urandom);
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Drain and confirm nothing was lost.
    in_valid  = 16'h0000;
    out_ready = 1'b1;
    repeat (3) step();
    for (int k = 0; k < 16; k++) chk("drain_empty", 32'(exp_q[k].size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
